hub_message_router: RTL

HUB_MESSAGE_ROUTER -- requirements
Module: hub_message_router

---
 rtl/hub_message_router.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hub_message_router.sv
// Hub crossbar: one message per cycle from NUM_LINKS inputs into single-entry
// output slots, with unicast, broadcast and drop routing and round-robin arbitration.
module hub_message_router #(
    parameter int NUM_LINKS    = 4,
    parameter int GT_FIFO_SIZE = 64,
    parameter int MSG_DEST_MSB = 63,
    parameter int MSG_DEST_LSB = 56
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_LINKS*GT_FIFO_SIZE-1:0] in_data,
    input  logic [NUM_LINKS-1:0]              in_valid,
    output logic [NUM_LINKS-1:0]              in_ready,
    output logic [NUM_LINKS*GT_FIFO_SIZE-1:0] out_data,
    output logic [NUM_LINKS-1:0]              out_valid,
    input  logic [NUM_LINKS-1:0]              out_ready,
    output logic [15:0]                       drop_count,
    output logic                              router_busy
);

    localparam int PTR_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
    localparam int DW    = MSG_DEST_MSB - MSG_DEST_LSB + 1;
    localparam int W     = GT_FIFO_SIZE;

    logic [NUM_LINKS*W-1:0]              out_data_q, out_data_d;
    logic [NUM_LINKS-1:0]                out_valid_q, out_valid_d;
    logic [15:0]                         drop_count_q, drop_count_d;
    logic [PTR_W-1:0]                    rr_ptr_q, rr_ptr_d;

    logic [NUM_LINKS-1:0][NUM_LINKS-1:0] tgt;
    logic [NUM_LINKS-1:0]                is_drop, elig, slot_free, grant;
    logic [DW-1:0]                       dest;
    logic [PTR_W-1:0]                    gnt_idx, cand;
    logic                                gnt_any;
    logic [W-1:0]                        gnt_data;
    int                                  scan;

    assign slot_free = ~out_valid_q | out_ready;

    // Destination decode: anything that is neither a valid link ID nor broadcast is a drop.
    always_comb begin
        tgt     = '0;
        is_drop = '1;
        elig    = '0;
        dest    = '0;
        for (int i = 0; i < NUM_LINKS; i++) begin
            dest = in_data[i*W+MSG_DEST_LSB +: DW];
            if (dest == {DW{1'b1}}) begin
                tgt[i]     = '1;
                is_drop[i] = 1'b0;
            end else begin
                for (int j = 0; j < NUM_LINKS; j++) begin
                    if (int'(dest) == j + 1) begin
                        tgt[i][j]  = 1'b1;
                        is_drop[i] = 1'b0;
                    end
                end
            end
            elig[i] = in_valid[i] && (is_drop[i] || ((tgt[i] & ~slot_free) == '0));
        end
    end

    // First eligible input at or after rr_ptr wins; ineligible inputs are skipped.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        scan    = 0;
        for (int k = 0; k < NUM_LINKS; k++) begin
            scan = int'(rr_ptr_q) + k;
            if (scan >= NUM_LINKS) scan = scan - NUM_LINKS;
            cand = PTR_W'(scan);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        grant    = gnt_any ? (NUM_LINKS'(1) << gnt_idx) : '0;
        gnt_data = in_data[gnt_idx*W +: W];
    end

    always_comb begin
        out_valid_d  = out_valid_q & ~out_ready;
        out_data_d   = out_data_q;
        drop_count_d = drop_count_q;
        rr_ptr_d     = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_LINKS - 1)) ? '0 : gnt_idx + 1'b1;
            if (is_drop[gnt_idx]) begin
                if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
            end else begin
                for (int j = 0; j < NUM_LINKS; j++) begin
                    if (tgt[gnt_idx][j]) begin
                        out_valid_d[j]       = 1'b1;
                        out_data_d[j*W +: W] = gnt_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q   <= '0;
            out_valid_q  <= '0;
            drop_count_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            drop_count_q <= drop_count_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign in_ready    = reset ? '0 : grant;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign drop_count  = drop_count_q;
    assign router_busy = (|in_valid) | (|out_valid_q);

endmodule
